// File: rtl/tiny_cpu_pkg.sv
// Shared types and widths for the tiny_cpu data-memory path.
`timescale 1ns/1ps
package tiny_cpu_pkg;

  localparam int unsigned DMEM_WORD_W = 32;
  localparam int unsigned DMEM_STRB_W = 4;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } dmem_state_t;

endpackage

// File: rtl/tiny_dmem_array.sv
// Single-port word RAM with per-byte write enables and a registered read port.
`timescale 1ns/1ps
module tiny_dmem_array
  import tiny_cpu_pkg::*;
#(
  parameter  int unsigned DEPTH_WORDS = 256,
  localparam int unsigned AW          = $clog2(DEPTH_WORDS)
) (
  input  logic                   clk,
  input  logic                   en,
  input  logic                   we,
  input  logic [DMEM_STRB_W-1:0] wstrb,
  input  logic [AW-1:0]          addr,
  input  logic [DMEM_WORD_W-1:0] wdata,
  output logic [DMEM_WORD_W-1:0] rdata
);

  logic [DMEM_WORD_W-1:0] mem [DEPTH_WORDS];

  // Read data only moves on a read access, so it holds for the whole response.
  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        for (int unsigned i = 0; i < DMEM_STRB_W; i++) begin
          if (wstrb[i]) begin
            mem[addr][8*i +: 8] <= wdata[8*i +: 8];
          end
        end
      end else begin
        rdata <= mem[addr];
      end
    end
  end

endmodule

// File: rtl/tiny_dmem_responder.sv
// Load/store responder: one outstanding word request, programmable wait, then a held response.
`timescale 1ns/1ps
module tiny_dmem_responder
  import tiny_cpu_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned LATENCY     = 2,
  parameter logic [31:0] BASE_ADDR   = '0
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic                   req_we,
  input  logic [31:0]            req_addr,
  input  logic [DMEM_WORD_W-1:0] req_wdata,
  input  logic [DMEM_STRB_W-1:0] req_wstrb,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [DMEM_WORD_W-1:0] rsp_rdata,
  output logic                   rsp_err
);

  localparam int unsigned AW       = $clog2(DEPTH_WORDS);
  localparam logic [3:0]  CNT_INIT = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

  dmem_state_t state, state_next;
  logic [3:0]  cnt;

  logic                   cap_we;
  logic [31:0]            cap_addr;
  logic [DMEM_WORD_W-1:0] cap_wdata;
  logic [DMEM_STRB_W-1:0] cap_wstrb;

  logic                   accept, enter_resp, rsp_hs;
  logic                   cur_we, cur_err;
  logic [31:0]            cur_addr, offset, word_idx;
  logic [DMEM_WORD_W-1:0] cur_wdata, ram_rdata;
  logic [DMEM_STRB_W-1:0] cur_wstrb;
  logic                   ram_en, rd_sel;

  assign req_ready = (state == IDLE) && !RST;
  assign accept    = req_valid && req_ready;
  assign rsp_valid = (state == RESP);
  assign rsp_hs    = rsp_valid && rsp_ready;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    enter_resp = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          if (LATENCY == 0) begin
            state_next = RESP;
            enter_resp = 1'b1;
          end else begin
            state_next = WAIT;
          end
        end
      end
      WAIT: begin
        if (cnt == '0) begin
          state_next = RESP;
          enter_resp = 1'b1;
        end
      end
      RESP: begin
        if (rsp_hs) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // With zero latency the RAM access happens on the accept edge, so the live
  // request fields feed the RAM directly instead of the captured copy.
  always_comb begin
    cur_we    = (state == IDLE) ? req_we    : cap_we;
    cur_addr  = (state == IDLE) ? req_addr  : cap_addr;
    cur_wdata = (state == IDLE) ? req_wdata : cap_wdata;
    cur_wstrb = (state == IDLE) ? req_wstrb : cap_wstrb;
    offset    = cur_addr - BASE_ADDR;
    word_idx  = offset >> 2;
    cur_err   = (cur_addr[1:0] != 2'b00) || (cur_addr < BASE_ADDR) ||
                (word_idx >= 32'(DEPTH_WORDS));
    ram_en    = enter_resp && !cur_err && !RST;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cnt       <= '0;
      cap_we    <= 1'b0;
      cap_addr  <= '0;
      cap_wdata <= '0;
      cap_wstrb <= '0;
      rsp_err   <= 1'b0;
      rd_sel    <= 1'b0;
    end else begin
      if (accept) begin
        cap_we    <= req_we;
        cap_addr  <= req_addr;
        cap_wdata <= req_wdata;
        cap_wstrb <= req_wstrb;
        cnt       <= CNT_INIT;
      end else if ((state == WAIT) && (cnt != '0)) begin
        cnt <= cnt - 4'd1;
      end
      if (enter_resp) begin
        rsp_err <= cur_err;
        rd_sel  <= !cur_err && !cur_we;
      end else if (rsp_hs) begin
        rsp_err <= 1'b0;
        rd_sel  <= 1'b0;
      end
    end
  end

  assign rsp_rdata = rd_sel ? ram_rdata : '0;

  tiny_dmem_array #(
    .DEPTH_WORDS(DEPTH_WORDS)
  ) u_array (
    .clk  (CLK),
    .en   (ram_en),
    .we   (cur_we),
    .wstrb(cur_wstrb),
    .addr (word_idx[AW-1:0]),
    .wdata(cur_wdata),
    .rdata(ram_rdata)
  );

endmodule

// File: tb/tb_tiny_dmem_responder.sv
// Directed bench for tiny_dmem_responder: main instance at LATENCY=2 plus a latency sweep.
`timescale 1ns/1ps
module tb_tiny_dmem_responder;

  logic        CLK = 1'b0;
  logic        RST;
  logic        req_valid, req_ready, req_we;
  logic [31:0] req_addr, req_wdata;
  logic [3:0]  req_wstrb;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [31:0] rsp_rdata;

  logic        s_req_valid, s_rsp_ready;
  logic [2:0]  s_req_ready, s_rsp_valid, s_rsp_err;
  logic [31:0] s_rsp_rdata [3];

  int n_cmp = 0;
  int n_bad = 0;

  always #5 CLK = ~CLK;

  tiny_dmem_responder #(
    .DEPTH_WORDS(256),
    .LATENCY    (2),
    .BASE_ADDR  (32'h0)
  ) u_dut (
    .CLK      (CLK),
    .RST      (RST),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_we   (req_we),
    .req_addr (req_addr),
    .req_wdata(req_wdata),
    .req_wstrb(req_wstrb),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata),
    .rsp_err  (rsp_err)
  );

  for (genvar g = 0; g < 3; g++) begin : g_sweep
    localparam int unsigned LAT = (g == 0) ? 0 : (g == 1) ? 1 : 7;
    tiny_dmem_responder #(
      .DEPTH_WORDS(16),
      .LATENCY    (LAT),
      .BASE_ADDR  (32'h0)
    ) u_sw (
      .CLK      (CLK),
      .RST      (RST),
      .req_valid(s_req_valid),
      .req_ready(s_req_ready[g]),
      .req_we   (1'b1),
      .req_addr (32'h0),
      .req_wdata(32'h0000_00A5),
      .req_wstrb(4'hF),
      .rsp_valid(s_rsp_valid[g]),
      .rsp_ready(s_rsp_ready),
      .rsp_rdata(s_rsp_rdata[g]),
      .rsp_err  (s_rsp_err[g])
    );
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // One full request/response; 'hold' cycles of backpressure with a competing request.
  task automatic txn(input string tag, input logic we, input logic [31:0] addr,
                     input logic [31:0] wdata, input logic [3:0] strb, input int hold,
                     output logic [31:0] rdata, output logic err, output int lat);
    int k;
    @(posedge CLK); #1;
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata; req_wstrb = strb;
    k = 0;
    @(negedge CLK);
    while (!req_ready && k < 20) begin
      @(negedge CLK);
      k++;
    end
    check_eq({tag, "_accept"}, 32'(req_ready), 32'd1);
    @(posedge CLK); #1;
    req_valid = 1'b0; req_we = ~we; req_addr = 32'hFFFF_FFF0; req_wdata = ~wdata; req_wstrb = ~strb;
    lat = 1;
    @(negedge CLK);
    while (!rsp_valid && lat < 40) begin
      @(negedge CLK);
      lat++;
    end
    check_eq({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd1);
    rdata = rsp_rdata;
    err   = rsp_err;
    for (int i = 0; i < hold; i++) begin
      @(posedge CLK); #1;
      req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h0;
      @(negedge CLK);
      check_eq($sformatf("%s_hold%0d_valid", tag, i), 32'(rsp_valid), 32'd1);
      check_eq($sformatf("%s_hold%0d_rdata", tag, i), rsp_rdata, rdata);
      check_eq($sformatf("%s_hold%0d_err", tag, i), 32'(rsp_err), 32'(err));
      check_eq($sformatf("%s_hold%0d_req_ready", tag, i), 32'(req_ready), 32'd0);
    end
    @(posedge CLK); #1;
    req_valid = 1'b0; rsp_ready = 1'b1;
    @(posedge CLK); #1;
    rsp_ready = 1'b0;
    @(negedge CLK);
    check_eq({tag, "_done_valid"}, 32'(rsp_valid), 32'd0);
    check_eq({tag, "_done_ready"}, 32'(req_ready), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [31:0] rd;
    logic        er;
    int          lat;
    int          slat [3];

    RST = 1'b1;
    req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0; req_wstrb = '0;
    rsp_ready = 1'b0; s_req_valid = 1'b0; s_rsp_ready = 1'b0;
    repeat (2) @(posedge CLK);
    #1 RST = 1'b0;
    @(negedge CLK);
    check_eq("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check_eq("rst_req_ready", 32'(req_ready), 32'd1);
    check_eq("rst_rsp_err", 32'(rsp_err), 32'd0);
    check_eq("rst_rsp_rdata", rsp_rdata, 32'd0);

    // Store then load.
    txn("sw0", 1'b1, 32'h0, 32'h0000_002A, 4'hF, 0, rd, er, lat);
    check_eq("sw0_err", 32'(er), 32'd0);
    check_eq("sw0_rdata", rd, 32'd0);
    check_eq("sw0_lat", 32'(lat), 32'd3);
    txn("lw0", 1'b0, 32'h0, 32'h0, 4'h0, 0, rd, er, lat);
    check_eq("lw0_rdata", rd, 32'h0000_002A);
    check_eq("lw0_err", 32'(er), 32'd0);
    check_eq("lw0_lat", 32'(lat), 32'd3);

    // Byte strobes.
    txn("sw4a", 1'b1, 32'h4, 32'hAABB_CCDD, 4'hF, 0, rd, er, lat);
    txn("sw4b", 1'b1, 32'h4, 32'h1122_3344, 4'h5, 0, rd, er, lat);
    check_eq("sw4b_err", 32'(er), 32'd0);
    txn("lw4", 1'b0, 32'h4, 32'h0, 4'h0, 0, rd, er, lat);
    check_eq("lw4_rdata", rd, 32'hAA22_CC44);

    // Backpressure.
    txn("bp", 1'b0, 32'h4, 32'h0, 4'h0, 5, rd, er, lat);
    check_eq("bp_rdata", rd, 32'hAA22_CC44);

    // Address errors and strobe-free store.
    txn("lw_mis", 1'b0, 32'h2, 32'h0, 4'h0, 0, rd, er, lat);
    check_eq("lw_mis_err", 32'(er), 32'd1);
    check_eq("lw_mis_rdata", rd, 32'd0);
    txn("lw_oor", 1'b0, 32'h400, 32'h0, 4'h0, 0, rd, er, lat);
    check_eq("lw_oor_err", 32'(er), 32'd1);
    check_eq("lw_oor_rdata", rd, 32'd0);
    txn("sw_mis", 1'b1, 32'h3, 32'hFFFF_FFFF, 4'hF, 0, rd, er, lat);
    check_eq("sw_mis_err", 32'(er), 32'd1);
    txn("lw0_after_mis", 1'b0, 32'h0, 32'h0, 4'h0, 0, rd, er, lat);
    check_eq("lw0_after_mis_rdata", rd, 32'h0000_002A);
    txn("sw_nostrb", 1'b1, 32'h0, 32'hDEAD_BEEF, 4'h0, 0, rd, er, lat);
    check_eq("sw_nostrb_err", 32'(er), 32'd0);
    txn("lw0_after_nostrb", 1'b0, 32'h0, 32'h0, 4'h0, 0, rd, er, lat);
    check_eq("lw0_after_nostrb_rdata", rd, 32'h0000_002A);
    txn("sw_last", 1'b1, 32'h3FC, 32'hCAFE_F00D, 4'hF, 0, rd, er, lat);
    check_eq("sw_last_err", 32'(er), 32'd0);
    txn("lw_last", 1'b0, 32'h3FC, 32'h0, 4'h0, 0, rd, er, lat);
    check_eq("lw_last_rdata", rd, 32'hCAFE_F00D);
    check_eq("lw_last_err", 32'(er), 32'd0);

    // Reset while a store is waiting.
    txn("sw8", 1'b1, 32'h8, 32'h1234_5678, 4'hF, 0, rd, er, lat);
    @(posedge CLK); #1;
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h8; req_wdata = 32'h0000_0055; req_wstrb = 4'hF;
    @(negedge CLK);
    check_eq("mor_accept", 32'(req_ready), 32'd1);
    @(posedge CLK); #1;
    req_valid = 1'b0;
    @(negedge CLK);
    check_eq("mor_in_wait_ready", 32'(req_ready), 32'd0);
    RST = 1'b1;
    @(posedge CLK);
    @(posedge CLK); #1;
    RST = 1'b0;
    @(negedge CLK);
    check_eq("mor_rsp_valid", 32'(rsp_valid), 32'd0);
    check_eq("mor_req_ready", 32'(req_ready), 32'd1);
    check_eq("mor_rsp_err", 32'(rsp_err), 32'd0);
    repeat (4) @(negedge CLK);
    check_eq("mor_no_late_rsp", 32'(rsp_valid), 32'd0);
    txn("lw8", 1'b0, 32'h8, 32'h0, 4'h0, 0, rd, er, lat);
    check_eq("lw8_rdata", rd, 32'h1234_5678);

    // Latency sweep: responses land in cycle N+1+LATENCY.
    @(posedge CLK); #1;
    s_req_valid = 1'b1;
    @(negedge CLK);
    check_eq("sweep_accept", 32'(s_req_ready), 32'h7);
    @(posedge CLK); #1;
    s_req_valid = 1'b0;
    for (int g = 0; g < 3; g++) slat[g] = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge CLK);
      for (int g = 0; g < 3; g++) begin
        if (s_rsp_valid[g] && slat[g] == 0) begin
          slat[g] = k;
          check_eq($sformatf("sweep%0d_err", g), 32'(s_rsp_err[g]), 32'd0);
          check_eq($sformatf("sweep%0d_rdata", g), s_rsp_rdata[g], 32'd0);
        end
      end
    end
    check_eq("sweep_lat0", 32'(slat[0]), 32'd1);
    check_eq("sweep_lat1", 32'(slat[1]), 32'd2);
    check_eq("sweep_lat7", 32'(slat[2]), 32'd8);
    @(posedge CLK); #1;
    s_rsp_ready = 1'b1;
    @(posedge CLK); #1;
    s_rsp_ready = 1'b0;
    @(negedge CLK);
    check_eq("sweep_done_valid", 32'(s_rsp_valid), 32'd0);
    check_eq("sweep_done_ready", 32'(s_req_ready), 32'h7);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
